// File: rtl/axis_swap_pkg.sv
// Shared types and constants for the two-source byte-swapping AXI Stream arbiter.
package axis_swap_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GNT_A = 2'b01,
      GNT_B = 2'b10
   } arb_state_t;

   localparam logic [1:0] GRANT_NONE = 2'b00;
   localparam logic [1:0] GRANT_A    = 2'b01;
   localparam logic [1:0] GRANT_B    = 2'b10;

   localparam int SWAP_LANE_BYTES = 4;

   function automatic logic [31:0] swap_bytes32(input logic [31:0] d);
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
   endfunction

   function automatic logic [3:0] reverse_keep4(input logic [3:0] k);
      return {k[0], k[1], k[2], k[3]};
   endfunction

endpackage

// File: rtl/swap_lane32.sv
// Combinational 32-bit byte-order reversal of data and keep, selected by swap.
import axis_swap_pkg::*;

module swap_lane32 (
   input  logic                           swap,
   input  logic [SWAP_LANE_BYTES*8-1:0]   in_data,
   input  logic [SWAP_LANE_BYTES-1:0]     in_keep,
   output logic [SWAP_LANE_BYTES*8-1:0]   out_data,
   output logic [SWAP_LANE_BYTES-1:0]     out_keep
);

   assign out_data = swap ? swap_bytes32(in_data) : in_data;
   assign out_keep = swap ? reverse_keep4(in_keep) : in_keep;

endmodule

// File: rtl/axis_swap_arbiter.sv
// Packet-granular round-robin arbiter sharing one byte-swap lane between two AXIS sources.
// Optional packet counters are built when AXIS_SWAP_ARB_STATS_EN is defined.
import axis_swap_pkg::*;

module axis_swap_arbiter #(
   parameter int NUM_BYTES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     swap_en_a,
   input  logic                     swap_en_b,
   input  logic [NUM_BYTES*8-1:0]   a_TDATA,
   input  logic [NUM_BYTES-1:0]     a_TKEEP,
   input  logic                     a_TLAST,
   input  logic                     a_TVALID,
   output logic                     a_TREADY,
   input  logic [NUM_BYTES*8-1:0]   b_TDATA,
   input  logic [NUM_BYTES-1:0]     b_TKEEP,
   input  logic                     b_TLAST,
   input  logic                     b_TVALID,
   output logic                     b_TREADY,
   output logic [NUM_BYTES*8-1:0]   out_TDATA,
   output logic [NUM_BYTES-1:0]     out_TKEEP,
   output logic                     out_TLAST,
   output logic                     out_TVALID,
   input  logic                     out_TREADY,
`ifdef AXIS_SWAP_ARB_STATS_EN
   output logic [15:0]              pkt_cnt_a,
   output logic [15:0]              pkt_cnt_b,
`endif
   output logic [1:0]               grant
);

   arb_state_t                r_state;
   logic                      r_swap_q;
   logic                      r_last_b;
   logic [NUM_BYTES*8-1:0]    r_out_data;
   logic [NUM_BYTES-1:0]      r_out_keep;
   logic                      r_out_last;
   logic                      r_out_valid;

   logic [NUM_BYTES*8-1:0]    w_sel_data;
   logic [NUM_BYTES-1:0]      w_sel_keep;
   logic                      w_sel_last;
   logic                      w_sel_valid;
   logic [NUM_BYTES*8-1:0]    w_swp_data;
   logic [NUM_BYTES-1:0]      w_swp_keep;
   logic                      w_can_take;
   logic                      w_accept;
   logic                      w_pick_a;
   logic                      w_pick_b;
   logic [1:0]                w_grant;

   // A tie goes to whichever source was not served last.
   assign w_pick_a   = a_TVALID && (!b_TVALID || r_last_b);
   assign w_pick_b   = b_TVALID && (!a_TVALID || !r_last_b);
   assign w_can_take = !r_out_valid || out_TREADY;
   assign a_TREADY   = (r_state == GNT_A) && w_can_take;
   assign b_TREADY   = (r_state == GNT_B) && w_can_take;
   assign w_accept   = w_sel_valid && w_can_take && (r_state != IDLE);

   // Source mux in front of the shared swap lane.
   always_comb begin
      w_sel_data  = a_TDATA;
      w_sel_keep  = a_TKEEP;
      w_sel_last  = a_TLAST;
      w_sel_valid = 1'b0;
      w_grant     = GRANT_NONE;
      case (r_state)
         GNT_A: begin
            w_sel_valid = a_TVALID;
            w_grant     = GRANT_A;
         end
         GNT_B: begin
            w_sel_data  = b_TDATA;
            w_sel_keep  = b_TKEEP;
            w_sel_last  = b_TLAST;
            w_sel_valid = b_TVALID;
            w_grant     = GRANT_B;
         end
         default: begin
            w_sel_valid = 1'b0;
            w_grant     = GRANT_NONE;
         end
      endcase
   end

   assign grant = w_grant;

   swap_lane32 u_swap_lane (
      .swap     (r_swap_q),
      .in_data  (w_sel_data),
      .in_keep  (w_sel_keep),
      .out_data (w_swp_data),
      .out_keep (w_swp_keep)
   );

   // Grant FSM; swap enable and fairness pointer are captured only when a grant is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_swap_q <= 1'b0;
         r_last_b <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_a) begin
                  r_state  <= GNT_A;
                  r_swap_q <= swap_en_a;
                  r_last_b <= 1'b0;
               end else if (w_pick_b) begin
                  r_state  <= GNT_B;
                  r_swap_q <= swap_en_b;
                  r_last_b <= 1'b1;
               end
            end
            GNT_A, GNT_B: begin
               if (w_accept && w_sel_last) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Output register: a load wins over a drain, otherwise hold under backpressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_keep  <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_data  <= w_swp_data;
         r_out_keep  <= w_swp_keep;
         r_out_last  <= w_sel_last;
         r_out_valid <= 1'b1;
      end else if (out_TREADY) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_TDATA  = r_out_data;
   assign out_TKEEP  = r_out_keep;
   assign out_TLAST  = r_out_last;
   assign out_TVALID = r_out_valid;

`ifdef AXIS_SWAP_ARB_STATS_EN
   logic [15:0] r_pkt_cnt_a;
   logic [15:0] r_pkt_cnt_b;

   // Completed-packet counters, wrapping naturally at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pkt_cnt_a <= 16'h0000;
         r_pkt_cnt_b <= 16'h0000;
      end else if (w_accept && w_sel_last) begin
         if (r_state == GNT_A) begin
            r_pkt_cnt_a <= r_pkt_cnt_a + 16'h0001;
         end else begin
            r_pkt_cnt_b <= r_pkt_cnt_b + 16'h0001;
         end
      end
   end

   assign pkt_cnt_a = r_pkt_cnt_a;
   assign pkt_cnt_b = r_pkt_cnt_b;
`endif

endmodule

// File: tb/tb_axis_swap_arbiter.sv
// Directed, table-driven bench for axis_swap_arbiter with hand-computed expectations.
module tb_axis_swap_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        swap_en_a = 1'b0, swap_en_b = 1'b0;
   logic [31:0] a_TDATA = 32'h0, b_TDATA = 32'h0;
   logic [3:0]  a_TKEEP = 4'h0, b_TKEEP = 4'h0;
   logic        a_TLAST = 1'b0, a_TVALID = 1'b0, b_TLAST = 1'b0, b_TVALID = 1'b0;
   logic        a_TREADY, b_TREADY;
   logic [31:0] out_TDATA;
   logic [3:0]  out_TKEEP;
   logic        out_TLAST, out_TVALID;
   logic        out_TREADY = 1'b1;
   logic [1:0]  grant;
`ifdef AXIS_SWAP_ARB_STATS_EN
   logic [15:0] pkt_cnt_a, pkt_cnt_b;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axis_swap_arbiter #(.NUM_BYTES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .swap_en_a  (swap_en_a),
      .swap_en_b  (swap_en_b),
      .a_TDATA    (a_TDATA),
      .a_TKEEP    (a_TKEEP),
      .a_TLAST    (a_TLAST),
      .a_TVALID   (a_TVALID),
      .a_TREADY   (a_TREADY),
      .b_TDATA    (b_TDATA),
      .b_TKEEP    (b_TKEEP),
      .b_TLAST    (b_TLAST),
      .b_TVALID   (b_TVALID),
      .b_TREADY   (b_TREADY),
      .out_TDATA  (out_TDATA),
      .out_TKEEP  (out_TKEEP),
      .out_TLAST  (out_TLAST),
      .out_TVALID (out_TVALID),
      .out_TREADY (out_TREADY),
`ifdef AXIS_SWAP_ARB_STATS_EN
      .pkt_cnt_a  (pkt_cnt_a),
      .pkt_cnt_b  (pkt_cnt_b),
`endif
      .grant      (grant)
   );

   typedef struct {
      logic        av; logic [31:0] ad; logic [3:0] ak; logic al; logic sa;
      logic        bv; logic [31:0] bd; logic [3:0] bk; logic bl; logic sb;
      logic        ordy; logic rst_before;
      logic [1:0]  eg; logic ear; logic ebr; logic eov;
      logic [31:0] eod; logic [3:0] eok; logic eol;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(
      input logic av, input logic [31:0] ad, input logic [3:0] ak, input logic al, input logic sa,
      input logic bv, input logic [31:0] bd, input logic [3:0] bk, input logic bl, input logic sb,
      input logic ordy, input logic rb,
      input logic [1:0] eg, input logic ear, input logic ebr, input logic eov,
      input logic [31:0] eod, input logic [3:0] eok, input logic eol);
      vec_t x;
      x.av = av; x.ad = ad; x.ak = ak; x.al = al; x.sa = sa;
      x.bv = bv; x.bd = bd; x.bk = bk; x.bl = bl; x.sb = sb;
      x.ordy = ordy; x.rst_before = rb;
      x.eg = eg; x.ear = ear; x.ebr = ebr; x.eov = eov;
      x.eod = eod; x.eok = eok; x.eol = eol;
      return x;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic drive_idle();
      a_TVALID = 1'b0; a_TDATA = 32'h0; a_TKEEP = 4'h0; a_TLAST = 1'b0; swap_en_a = 1'b0;
      b_TVALID = 1'b0; b_TDATA = 32'h0; b_TKEEP = 4'h0; b_TLAST = 1'b0; swap_en_b = 1'b0;
      out_TREADY = 1'b1;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Apply one vector just after a rising edge, check on the falling edge.
   task automatic step(input vec_t x, input int idx);
      a_TVALID = x.av; a_TDATA = x.ad; a_TKEEP = x.ak; a_TLAST = x.al; swap_en_a = x.sa;
      b_TVALID = x.bv; b_TDATA = x.bd; b_TKEEP = x.bk; b_TLAST = x.bl; swap_en_b = x.sb;
      out_TREADY = x.ordy;
      @(negedge clk);
      chk("grant",    idx, {30'd0, grant},     {30'd0, x.eg});
      chk("a_TREADY", idx, {31'd0, a_TREADY},  {31'd0, x.ear});
      chk("b_TREADY", idx, {31'd0, b_TREADY},  {31'd0, x.ebr});
      chk("out_TVALID", idx, {31'd0, out_TVALID}, {31'd0, x.eov});
      if (x.eov) begin
         chk("out_TDATA", idx, out_TDATA, x.eod);
         chk("out_TKEEP", idx, {28'd0, out_TKEEP}, {28'd0, x.eok});
         chk("out_TLAST", idx, {31'd0, out_TLAST}, {31'd0, x.eol});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // A-only swapped packet
      tbl.push_back(mk(1'b1,32'h11223344,4'h3,1'b0,1'b1, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b1, 2'd0,1'b0,1'b0,1'b0,32'h0,4'h0,1'b0));
      tbl.push_back(mk(1'b1,32'h11223344,4'h3,1'b0,1'b1, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd1,1'b1,1'b0,1'b0,32'h0,4'h0,1'b0));
      tbl.push_back(mk(1'b1,32'hAABBCCDD,4'hF,1'b1,1'b1, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd1,1'b1,1'b0,1'b1,32'h44332211,4'hC,1'b0));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b1,32'hDDCCBBAA,4'hF,1'b1));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b0,32'h0,4'h0,1'b0));
      // Contest from reset: A,A,B,B then A wins the next tie
      tbl.push_back(mk(1'b1,32'hA0000001,4'hF,1'b0,1'b0, 1'b1,32'hB0000001,4'hF,1'b0,1'b0, 1'b1,1'b1, 2'd0,1'b0,1'b0,1'b0,32'h0,4'h0,1'b0));
      tbl.push_back(mk(1'b1,32'hA0000001,4'hF,1'b0,1'b0, 1'b1,32'hB0000001,4'hF,1'b0,1'b0, 1'b1,1'b0, 2'd1,1'b1,1'b0,1'b0,32'h0,4'h0,1'b0));
      tbl.push_back(mk(1'b1,32'hA0000002,4'hF,1'b1,1'b0, 1'b1,32'hB0000001,4'hF,1'b0,1'b0, 1'b1,1'b0, 2'd1,1'b1,1'b0,1'b1,32'hA0000001,4'hF,1'b0));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,32'hB0000001,4'hF,1'b0,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b1,32'hA0000002,4'hF,1'b1));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,32'hB0000001,4'hF,1'b0,1'b0, 1'b1,1'b0, 2'd2,1'b0,1'b1,1'b0,32'h0,4'h0,1'b0));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,32'hB0000002,4'hF,1'b1,1'b0, 1'b1,1'b0, 2'd2,1'b0,1'b1,1'b1,32'hB0000001,4'hF,1'b0));
      tbl.push_back(mk(1'b1,32'hA0000003,4'hF,1'b1,1'b0, 1'b1,32'hB0000003,4'hF,1'b1,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b1,32'hB0000002,4'hF,1'b1));
      tbl.push_back(mk(1'b1,32'hA0000003,4'hF,1'b1,1'b0, 1'b1,32'hB0000003,4'hF,1'b1,1'b0, 1'b1,1'b0, 2'd1,1'b1,1'b0,1'b0,32'h0,4'h0,1'b0));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,32'hB0000003,4'hF,1'b1,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b1,32'hA0000003,4'hF,1'b1));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,32'hB0000003,4'hF,1'b1,1'b0, 1'b1,1'b0, 2'd2,1'b0,1'b1,1'b0,32'h0,4'h0,1'b0));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b1,32'hB0000003,4'hF,1'b1));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b0,32'h0,4'h0,1'b0));
      // swap_en_b drops mid-packet: packet stays swapped, next packet is not
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,32'h01020304,4'h7,1'b0,1'b1, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b0,32'h0,4'h0,1'b0));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,32'h01020304,4'h7,1'b0,1'b0, 1'b1,1'b0, 2'd2,1'b0,1'b1,1'b0,32'h0,4'h0,1'b0));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,32'h05060708,4'hF,1'b1,1'b0, 1'b1,1'b0, 2'd2,1'b0,1'b1,1'b1,32'h04030201,4'hE,1'b0));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,32'h0A0B0C0D,4'h3,1'b1,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b1,32'h08070605,4'hF,1'b1));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,32'h0A0B0C0D,4'h3,1'b1,1'b0, 1'b1,1'b0, 2'd2,1'b0,1'b1,1'b0,32'h0,4'h0,1'b0));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b1,32'h0A0B0C0D,4'h3,1'b1));
      // Downstream stall for 3 cycles mid-packet
      tbl.push_back(mk(1'b1,32'h00000011,4'hF,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b0,32'h0,4'h0,1'b0));
      tbl.push_back(mk(1'b1,32'h00000011,4'hF,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd1,1'b1,1'b0,1'b0,32'h0,4'h0,1'b0));
      for (int i = 0; i < 3; i++)
         tbl.push_back(mk(1'b1,32'h00000022,4'hF,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b0,1'b0, 2'd1,1'b0,1'b0,1'b1,32'h00000011,4'hF,1'b0));
      tbl.push_back(mk(1'b1,32'h00000022,4'hF,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd1,1'b1,1'b0,1'b1,32'h00000011,4'hF,1'b0));
      tbl.push_back(mk(1'b1,32'h00000033,4'hF,1'b1,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd1,1'b1,1'b0,1'b1,32'h00000022,4'hF,1'b0));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b1,32'h00000033,4'hF,1'b1));
      tbl.push_back(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b0,32'h0,4'h0,1'b0));

      drive_idle();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_grant", 0, {30'd0, grant}, 32'd0);
      chk("rst_out_TVALID", 0, {31'd0, out_TVALID}, 32'd0);
      chk("rst_out_TDATA", 0, out_TDATA, 32'd0);
      chk("rst_out_TKEEP", 0, {28'd0, out_TKEEP}, 32'd0);
      chk("rst_out_TLAST", 0, {31'd0, out_TLAST}, 32'd0);
      chk("rst_a_TREADY", 0, {31'd0, a_TREADY}, 32'd0);
      chk("rst_b_TREADY", 0, {31'd0, b_TREADY}, 32'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst_before) do_reset();
         step(tbl[i], i);
      end

      // Reset in the middle of a 4-beat packet
      do_reset();
      step(mk(1'b1,32'hE0000001,4'hF,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b0,32'h0,4'h0,1'b0), 100);
      step(mk(1'b1,32'hE0000001,4'hF,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd1,1'b1,1'b0,1'b0,32'h0,4'h0,1'b0), 101);
      step(mk(1'b1,32'hE0000002,4'hF,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd1,1'b1,1'b0,1'b1,32'hE0000001,4'hF,1'b0), 102);
      a_TDATA = 32'hE0000003;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_grant", 103, {30'd0, grant}, 32'd0);
      chk("midrst_out_TVALID", 103, {31'd0, out_TVALID}, 32'd0);
      chk("midrst_out_TDATA", 103, out_TDATA, 32'd0);
      chk("midrst_out_TKEEP", 103, {28'd0, out_TKEEP}, 32'd0);
      chk("midrst_out_TLAST", 103, {31'd0, out_TLAST}, 32'd0);
      chk("midrst_a_TREADY", 103, {31'd0, a_TREADY}, 32'd0);
      drive_idle();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      // Fresh tie after reset: A wins, single-beat grants last one cycle
      step(mk(1'b1,32'h12345678,4'h1,1'b1,1'b1, 1'b1,32'h9ABCDEF0,4'hF,1'b1,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b0,32'h0,4'h0,1'b0), 104);
      step(mk(1'b1,32'h12345678,4'h1,1'b1,1'b1, 1'b1,32'h9ABCDEF0,4'hF,1'b1,1'b0, 1'b1,1'b0, 2'd1,1'b1,1'b0,1'b0,32'h0,4'h0,1'b0), 105);
      step(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,32'h9ABCDEF0,4'hF,1'b1,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b1,32'h78563412,4'h8,1'b1), 106);
      step(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,32'h9ABCDEF0,4'hF,1'b1,1'b0, 1'b1,1'b0, 2'd2,1'b0,1'b1,1'b0,32'h0,4'h0,1'b0), 107);
      step(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b1,32'h9ABCDEF0,4'hF,1'b1), 108);

`ifdef AXIS_SWAP_ARB_STATS_EN
      chk("pkt_cnt_a", 109, {16'd0, pkt_cnt_a}, 32'd1);
      chk("pkt_cnt_b", 109, {16'd0, pkt_cnt_b}, 32'd1);
      force dut.r_pkt_cnt_a = 16'hFFFF;
      #1;
      release dut.r_pkt_cnt_a;
      step(mk(1'b1,32'h00000001,4'hF,1'b1,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b0,32'h0,4'h0,1'b0), 110);
      step(mk(1'b1,32'h00000001,4'hF,1'b1,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd1,1'b1,1'b0,1'b0,32'h0,4'h0,1'b0), 111);
      step(mk(1'b0,32'h0,4'h0,1'b0,1'b0, 1'b0,32'h0,4'h0,1'b0,1'b0, 1'b1,1'b0, 2'd0,1'b0,1'b0,1'b1,32'h00000001,4'hF,1'b1), 112);
      chk("pkt_cnt_a_wrap", 113, {16'd0, pkt_cnt_a}, 32'd0);
      chk("pkt_cnt_b_hold", 113, {16'd0, pkt_cnt_b}, 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axis_swap_arbiter.md
# axis_swap_arbiter

Two-input, packet-granular round-robin arbiter that shares one 32-bit byte-swap datapath between two AXI Stream sources. Each source has its own swap-enable, which is sampled when that source's packet is granted. The merged, optionally byte-swapped stream leaves through one registered AXI Stream master. It sits upstream of network/host packers wherever two producers of different endianness feed one consumer.

## Interface
Parameters:
- NUM_BYTES, 4: bytes per beat; only 4 is supported, fixed by the swap lane.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- swap_en_a  in  1  byte-swap enable for source A, latched at grant.
- swap_en_b  in  1  byte-swap enable for source B, latched at grant.
- a_TDATA / a_TKEEP / a_TLAST / a_TVALID  in  32/4/1/1  source A slave stream.
- a_TREADY  out  1  source A ready.
- b_TDATA / b_TKEEP / b_TLAST / b_TVALID  in  32/4/1/1  source B slave stream.
- b_TREADY  out  1  source B ready.
- out_TDATA / out_TKEEP / out_TLAST / out_TVALID  out  32/4/1/1  registered master stream.
- out_TREADY  in  1  downstream ready.
- grant  out  2  current owner: 2'b00 idle, 2'b01 A, 2'b10 B.

## Operation
- FSM states:
  - IDLE: no owner.
  - GNT_A: source A owns the datapath.
  - GNT_B: source B owns the datapath.
- IDLE, one valid source: grant that source.
- IDLE, both sources valid: grant the source not served last. The last-served pointer resets to B, so A wins the first contest.
- On the IDLE→GNT transition:
  - Latch that source's swap_en into swap_q.
  - Update the last-served pointer.
- swap_en changes during a granted packet are ignored until that packet finishes.
- Granted source ready: x_TREADY = granted_x && (!out_TVALID || out_TREADY).
- Non-granted source ready is held at 0.
- On an accepted beat, load the output register:
  - TDATA: swap_q ? {d[7:0],d[15:8],d[23:16],d[31:24]} : d.
  - TKEEP: reversed under the same condition.
  - TLAST: passed unchanged.
- An accepted beat with TLAST=1 moves the FSM back to IDLE.
- out_TVALID:
  - Set on load.
  - Cleared when out_TREADY=1 and no new load occurs in that cycle.
- Simultaneous load and drain: the register takes the new beat and out_TVALID stays 1.
- grant mirrors the FSM state.

## Timing
- Reset values: state IDLE; grant 0; out_TVALID 0; out_TDATA 0; out_TKEEP 0; out_TLAST 0; a_TREADY 0; b_TREADY 0; swap_q 0; pointer = B.
- Latency: a beat accepted in cycle n appears on out_* in cycle n+1.
- Grant takes effect the cycle after IDLE sees TVALID. The first beat is accepted no earlier than one cycle after the request.
- After each TLAST acceptance there is exactly one IDLE cycle (a one-beat bubble per packet). Sustained throughput is 1 beat/cycle within a packet.
- Downstream backpressure:
  - out_* must hold stable while out_TVALID && !out_TREADY.
  - The granted TREADY is deasserted in the same cycle, combinationally from out_TREADY.
- Single-beat packet (TLAST on the first beat): grant lasts exactly one cycle, then IDLE.
- A source that drops TVALID mid-packet keeps its grant. No timeout, no preemption.
- Reset asserted mid-packet: the pending output beat is discarded, the FSM returns to IDLE, and the partial packet is not completed.

## Configuration
- AXIS_SWAP_ARB_STATS_EN defined:
  - Adds outputs pkt_cnt_a [15:0] and pkt_cnt_b [15:0].
  - Each counter increments on an accepted TLAST beat from its source and wraps 16'hFFFF→0.
  - Both counters reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Package axis_swap_pkg:
  - state enum arb_state_t {IDLE, GNT_A, GNT_B}.
  - GRANT_NONE / GRANT_A / GRANT_B constants.
  - SWAP_LANE_BYTES = 4.
- Sub-module swap_lane32: purely combinational data/keep reversal selected by swap. It is instantiated once, after the source mux and before the output register.

## Test plan
- A only, swap_en_a=1, packet 0x11223344 (TKEEP 4'b0011), then 0xAABBCCDD (TLAST, TKEEP 4'b1111) → out 0x44332211 (TKEEP 4'b1100), then 0xDDCCBBAA; grant 01 then 00.
- A and B valid in the same cycle from reset, each with a 2-beat packet → output order A,A,B,B, with one idle cycle between packets; on the next contest A is served after B.
- swap_en_b toggled 1→0 mid-packet of B → all beats of that packet are swapped; the next B packet is unswapped.
- out_TREADY held 0 for 3 cycles mid-packet → out_* stable, a_TREADY=0, no beat lost or duplicated.
- rst pulsed during beat 2 of a 4-beat packet → all outputs at their reset values in the same cycle; the next packet starts cleanly with a new grant.
- With AXIS_SWAP_ARB_STATS_EN, 3 A packets and 2 B packets → pkt_cnt_a=3, pkt_cnt_b=2; preset pkt_cnt_a to 16'hFFFF, one more packet → 0.
